// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: slot prescaler, double-buffered
// display registers, dead-time, brightness windowing and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES = 131072,
  parameter int DEAD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  input  logic [3:0]  brightness,
  input  logic        lz_suppress,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        frame_start
);

  localparam int CW   = $clog2(SLOT_CYCLES);
  localparam int EW   = CW + 1;
  localparam int UNIT = (SLOT_CYCLES - DEAD_CYCLES) / 16;

  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [EW-1:0] DEAD_E   = EW'(DEAD_CYCLES);
  localparam logic [EW-1:0] UNIT_E   = EW'(UNIT);

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [3:0]    bright_q;
  logic [15:0]   stage_value;
  logic [3:0]    stage_dp;
  logic          pending;
  logic [15:0]   active_value;
  logic [3:0]    active_dp;

  logic          slot_end;
  logic          boundary;
  logic          commit;
  logic [EW-1:0] cnt_e;
  logic [EW-1:0] on_end;
  logic          in_window;
  logic          blank;
  logic [3:0]    anode_d;
  logic [3:0]    digit_d;
  logic          dp_d;
  logic          frame_start_d;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (sel == 2'd3);
  // A load arriving in the boundary cycle itself still makes this frame.
  assign commit   = boundary && (pending || load);

  // NOTE: every signal driven here gets a value before any condition so no latch is inferred.
  always_comb begin
    cnt_e         = {1'b0, cnt};
    on_end        = DEAD_E + UNIT_E * (EW'(bright_q) + EW'(1));
    in_window     = (cnt_e >= DEAD_E) && (cnt_e < on_end);
    // Digit sel and every digit above it are zero; digit 0 always shows.
    blank         = lz_suppress && (sel != 2'd0) &&
                    ((active_value >> {sel, 2'b00}) == 16'd0);
    anode_d       = 4'b1111;
    if (in_window && !blank) anode_d = ~(4'b0001 << sel);
    digit_d       = active_value[{sel, 2'b00} +: 4];
    dp_d          = ~active_dp[sel];
    frame_start_d = (cnt == '0) && (sel == 2'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: staging/active buffers are reset because a reset must discard a pending update.
      cnt          <= '0;
      sel          <= 2'd0;
      bright_q     <= 4'd0;
      stage_value  <= 16'd0;
      stage_dp     <= 4'd0;
      pending      <= 1'b0;
      active_value <= 16'd0;
      active_dp    <= 4'd0;
      load_ack     <= 1'b0;
      anode        <= 4'b1111;
      digit        <= 4'd0;
      dp           <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) sel <= sel + 2'd1;
      if (cnt == '0) bright_q <= brightness;

      if (load) begin
        stage_value <= value;
        stage_dp    <= dp_in;
      end

      if (commit) begin
        active_value <= load ? value : stage_value;
        active_dp    <= load ? dp_in : stage_dp;
        pending      <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      load_ack    <= commit;
      anode       <= anode_d;
      digit       <= digit_d;
      dp          <= dp_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the four-digit seven-segment display. Owns the digit-slot prescaler and drives the active-low anodes, the 4-bit hex nibble for the segment decoder and the decimal point. Display updates are double-buffered and committed only at frame boundaries. Also applies dead-time ghosting suppression, 16-level brightness and leading-zero blanking.

## Interface
- SLOT_CYCLES, 131072: clocks per digit slot; a frame is 4 slots.
- DEAD_CYCLES, 256: anode-off cycles at the start of every slot. SLOT_CYCLES-DEAD_CYCLES must be a positive multiple of 16.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- value  in  16  four hex digits; [3:0] is digit 0 (rightmost) … [15:12] is digit 3.
- dp_in  in  4  decimal point per digit, 1 = lit; bit k maps to digit k.
- load  in  1  update request; value/dp_in are captured in every cycle load=1.
- load_ack  out  1  one-cycle pulse when the captured value becomes visible.
- brightness  in  4  0..15; sets on-time per slot.
- lz_suppress  in  1  1 = blank leading zero digits.
- anode  out  4  active-low digit enables; at most one bit is low.
- digit  out  4  nibble for the segment decoder.
- dp  out  1  active-low decimal point.
- frame_start  out  1  one-cycle pulse marking the first output cycle of slot 0.

## Operation
- Internal state:
  - cnt: 0..SLOT_CYCLES-1, wraps.
  - sel: 0..3, advances when cnt==SLOT_CYCLES-1; wraps 3->0.
  - staging regs: value, dp.
  - pending flag.
  - active regs: value, dp.
  - bright_q: brightness sampled when cnt==0.
- Frame boundary: the cycle with cnt==SLOT_CYCLES-1 and sel==3.
- Load handshake:
  - load=1 writes staging and sets pending; the last load before a boundary wins.
  - At the boundary, if pending or load is set, active is loaded with staging (or with that cycle's value/dp_in when load=1), pending clears, and load_ack=1 on the next cycle.
  - No other cycle changes active.
- On-window per slot:
  - unit = (SLOT_CYCLES-DEAD_CYCLES)/16.
  - on_len = unit*(bright_q+1).
  - The anode is enabled when DEAD_CYCLES <= cnt < DEAD_CYCLES+on_len.
  - Brightness 15 keeps the anode on to the end of the slot.
- Digit k is blanked (anode stays high all slot) when lz_suppress=1, active digit k is 0, and all higher digits are 0.
  - Digit 0 is never blanked.
  - lz_suppress is evaluated live, not buffered.
- digit = active nibble[sel] and dp = ~active_dp[sel] for the whole slot, including the dead time and blanked slots.

## Timing
- anode, digit, dp and frame_start are registered: they reflect cnt/sel from the previous cycle, a fixed latency of 1 clock.
- frame_start=1 in the cycle after internal cnt==0 && sel==0.
- Reset values while rst_n=0:
  - anode=4'b1111, digit=0, dp=1, load_ack=0, frame_start=0.
  - cnt=0, sel=0, bright_q=0.
  - pending=0; staging and active all 0.
- First cycle after rst_n rises: cnt=0, sel=0. frame_start pulses on the second cycle after release.
- A reset asserted mid-frame discards any pending load: no load_ack is issued and active returns to 0.
- A brightness change mid-slot takes effect in the next slot.
- load during a load_ack cycle sets pending for the next frame.
- Wrap-around: cnt and sel roll over with no idle cycle, so the frame period is exactly 4*SLOT_CYCLES.

## Test plan
All scenarios use SLOT_CYCLES=48 and DEAD_CYCLES=16, so unit=2.
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Required: anode=1111, dp=1 and load_ack=0 throughout reset. frame_start=1 on the second cycle after release, then again every 192 cycles.
- Basic display:
  - Stimulus: load 16'h1234, dp_in=4'b0010, brightness=15, lz_suppress=0.
  - Required: after load_ack, the slots show digit=4,3,2,1. Each anode bit is low for 32 cycles starting 16 cycles into its slot (+1 clock latency). dp=0 only in slot 1.
- Mid-frame loads:
  - Stimulus: load 16'hAAAA, then 16'hBBBB, both before the boundary.
  - Required: the old value is shown until the boundary. Exactly one load_ack, in the cycle after the boundary, and the display then shows B in all digits.
- Leading-zero blanking:
  - Stimulus: active 16'h0050, lz_suppress=1.
  - Required: anode[3] and anode[2] never go low. Slot 1 shows digit=5 and slot 0 shows digit=0, both with the anode active.
- Brightness:
  - Stimulus: brightness=0, then change it to 7 at cnt=20 of slot 1.
  - Required: slot 1 anode is low for 2 cycles; slot 2 anode is low for 16 cycles.
- Reset with pending load:
  - Stimulus: load 16'h9999, then pulse rst_n=0 for 1 cycle before the boundary.
  - Required: no load_ack, and after release the display shows digit=0 in all slots.
